// File: rtl/slow_ram_responder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// slow_ram_responder_pkg : state encoding and default geometry shared with the
//                          initiator FSM and the bench.
// Revision : 1.0
// ----------------------------------------------------------------------------
package slow_ram_responder_pkg;

  localparam int c_DEF_AW        = 4;
  localparam int c_DEF_DW        = 8;
  localparam int c_DEF_SLOW_BASE = 8;
  localparam int c_DEF_DELAY     = 1;

  typedef enum logic [0:0] {
    ST_Idle   = 1'b0,
    ST_Commit = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/slow_ram_responder_ram_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// slow_ram_responder_ram_array : 2**AW x DW register array, synchronous write,
//                                combinational read, async clear to zero.
// Revision : 1.0
// ----------------------------------------------------------------------------
module slow_ram_responder_ram_array #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          Clock,
  input  logic          ResetN,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int c_DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [c_DEPTH];

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/slow_ram_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// slow_ram_responder : Read/Write strobe responder with a slow upper region
//                      that stretches writes by DELAY commit cycles.
// Revision : 1.0
// ----------------------------------------------------------------------------
module slow_ram_responder
  import slow_ram_responder_pkg::*;
#(
  parameter int AW        = c_DEF_AW,
  parameter int DW        = c_DEF_DW,
  parameter int SLOW_BASE = c_DEF_SLOW_BASE,
  parameter int DELAY     = c_DEF_DELAY
) (
  input  logic          Clock,
  input  logic          ResetN,
  input  logic          Read,
  input  logic          Write,
  input  logic [AW-1:0] Addr,
  input  logic [DW-1:0] WrData,
  input  logic          ErrClear,
  output logic          SlowRAM,
  output logic [DW-1:0] RdData,
  output logic          RdValid,
  output logic          WrDone,
  output logic          Busy,
  output logic          ProtoErr
);

  localparam int              c_CW        = (DELAY < 2) ? 1 : $clog2(DELAY + 1);
  localparam logic [c_CW-1:0] c_DELAY     = c_CW'(DELAY);
  localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);
  localparam logic [AW:0]     c_SLOW_BASE = (AW + 1)'(SLOW_BASE);

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic [AW-1:0]   r_pend_addr;
  logic [DW-1:0]   r_pend_data;

  logic          w_busy, w_err, w_rd_ok, w_wr_ok, w_slow_addr;
  logic          w_fast_wr, w_slow_wr, w_commit, w_bypass;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_waddr;
  logic [DW-1:0] w_ram_wdata, w_ram_rdata;

  assign w_busy      = (r_state == ST_Commit);
  assign w_err       = (Read & Write) | (Write & w_busy);
  assign w_rd_ok     = Read & ~Write;
  assign w_wr_ok     = Write & ~Read & ~w_busy;
  assign w_slow_addr = ({1'b0, Addr} >= c_SLOW_BASE);
  assign w_fast_wr   = w_wr_ok & ~w_slow_addr;
  assign w_slow_wr   = w_wr_ok & w_slow_addr;
  assign w_commit    = w_busy & (r_cnt == c_ONE);
  assign w_bypass    = w_busy & (Addr == r_pend_addr);

  // Fast writes only happen in IDLE, so they never collide with a commit.
  assign w_ram_we    = w_fast_wr | w_commit;
  assign w_ram_waddr = w_commit ? r_pend_addr : Addr;
  assign w_ram_wdata = w_commit ? r_pend_data : WrData;

  assign SlowRAM = w_slow_wr;
  assign Busy    = w_busy;

  slow_ram_responder_ram_array #(
    .AW (AW),
    .DW (DW)
  ) u_ram_array (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (Addr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state     <= ST_Idle;
      r_cnt       <= '0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      RdData      <= '0;
      RdValid     <= 1'b0;
      WrDone      <= 1'b0;
      ProtoErr    <= 1'b0;
    end else begin
      RdValid  <= w_rd_ok;
      WrDone   <= w_fast_wr | w_commit;
      ProtoErr <= w_err | (ProtoErr & ~ErrClear);
      if (w_rd_ok) begin
        RdData <= w_bypass ? r_pend_data : w_ram_rdata;
      end
      case (r_state)
        ST_Idle: begin
          if (w_slow_wr) begin
            r_pend_addr <= Addr;
            r_pend_data <= WrData;
            r_cnt       <= c_DELAY;
            r_state     <= ST_Commit;
          end
        end
        ST_Commit: begin
          r_cnt <= r_cnt - c_ONE;
          if (w_commit) begin
            r_state <= ST_Idle;
          end
        end
        default: r_state <= ST_Idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_slow_ram_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_slow_ram_responder : directed table, reset/closed-loop sequences and
//                         random traffic against a cycle-schedule model.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_slow_ram_responder;

  localparam int AW        = 4;
  localparam int DW        = 8;
  localparam int SLOW_BASE = 8;
  localparam int DELAY     = 1;

  logic          Clock = 1'b0;
  logic          ResetN = 1'b0;
  logic          Read = 1'b0, Write = 1'b0, ErrClear = 1'b0;
  logic [AW-1:0] Addr = '0;
  logic [DW-1:0] WrData = '0;
  logic          SlowRAM, RdValid, WrDone, Busy, ProtoErr;
  logic [DW-1:0] RdData;

  slow_ram_responder #(
    .AW(AW), .DW(DW), .SLOW_BASE(SLOW_BASE), .DELAY(DELAY)
  ) dut (
    .Clock(Clock), .ResetN(ResetN), .Read(Read), .Write(Write), .Addr(Addr),
    .WrData(WrData), .ErrClear(ErrClear), .SlowRAM(SlowRAM), .RdData(RdData),
    .RdValid(RdValid), .WrDone(WrDone), .Busy(Busy), .ProtoErr(ProtoErr)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_err    = 0;

  // Model: memory image plus the cycle index of the last commit cycle of the
  // outstanding slow write; all outputs follow from those schedules.
  int            cyc;
  logic [DW-1:0] m_mem [2**AW];
  int            busy_until;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  logic [DW-1:0] e_rddata;
  logic          e_rdvalid, e_wrdone, e_err;

  typedef struct {
    logic          r, w, c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          slow, busy, rv, wd, err;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t tab [24];
  vec_t none_v;

  function automatic vec_t mk(int r, int w, int a, int d, int c,
                              int s, int b, int rv, int rd, int wd, int er);
    vec_t v;
    v.r = r[0]; v.w = w[0]; v.a = a[AW-1:0]; v.d = d[DW-1:0]; v.c = c[0];
    v.slow = s[0]; v.busy = b[0]; v.rv = rv[0]; v.rd = rd[DW-1:0];
    v.wd = wd[0]; v.err = er[0];
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
    busy_until = -1;
    p_addr = '0; p_data = '0;
    e_rddata = '0; e_rdvalid = 1'b0; e_wrdone = 1'b0; e_err = 1'b0;
  endtask

  // Called at posedge+1: drive, check at negedge, then advance the model.
  task automatic apply(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic c,
                       input string tag, input logic use_tab, input vec_t v,
                       output logic slow_seen);
    logic busy, err, wr_ok, slow, wd_n;
    Read = r; Write = w; Addr = a; WrData = d; ErrClear = c;
    busy  = (cyc <= busy_until);
    err   = (r & w) | (w & busy);
    wr_ok = w & ~r & ~busy;
    slow  = wr_ok & (int'(a) >= SLOW_BASE);
    @(negedge Clock);
    chk1({tag, " SlowRAM"},  SlowRAM,  slow);
    chk1({tag, " Busy"},     Busy,     busy);
    chk1({tag, " RdValid"},  RdValid,  e_rdvalid);
    chk8({tag, " RdData"},   RdData,   e_rddata);
    chk1({tag, " WrDone"},   WrDone,   e_wrdone);
    chk1({tag, " ProtoErr"}, ProtoErr, e_err);
    if (use_tab) begin
      chk1({tag, " tab SlowRAM"},  SlowRAM,  v.slow);
      chk1({tag, " tab Busy"},     Busy,     v.busy);
      chk1({tag, " tab RdValid"},  RdValid,  v.rv);
      chk8({tag, " tab RdData"},   RdData,   v.rd);
      chk1({tag, " tab WrDone"},   WrDone,   v.wd);
      chk1({tag, " tab ProtoErr"}, ProtoErr, v.err);
    end
    slow_seen = SlowRAM;
    @(posedge Clock); #1;
    e_rdvalid = r & ~w;
    if (e_rdvalid) e_rddata = (busy && a == p_addr) ? p_data : m_mem[a];
    wd_n = 1'b0;
    if (wr_ok && !slow) begin m_mem[a] = d; wd_n = 1'b1; end
    if (busy && cyc == busy_until) begin m_mem[p_addr] = p_data; wd_n = 1'b1; end
    if (slow) begin p_addr = a; p_data = d; busy_until = cyc + DELAY; end
    e_wrdone = wd_n;
    e_err = err ? 1'b1 : (c ? 1'b0 : e_err);
    cyc++;
  endtask

  task automatic idle(input string tag);
    logic s;
    apply(1'b0, 1'b0, '0, '0, 1'b0, tag, 1'b0, none_v, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    int   n_delay, n_slow_wr;
    none_v = mk(0,0,0,0,0, 0,0,0,0,0,0);
    //           r w  a  d     c  slow busy rv rd    wd err
    tab[0]  = mk(1,0, 3, 8'h00,0,  0,0,0,8'h00,0,0);
    tab[1]  = mk(0,1, 2, 8'h5A,0,  0,0,1,8'h00,0,0);
    tab[2]  = mk(1,0, 2, 8'h00,0,  0,0,0,8'h00,1,0);
    tab[3]  = mk(0,1, 9, 8'hC3,0,  1,0,1,8'h5A,0,0);
    tab[4]  = mk(0,0, 0, 8'h00,0,  0,1,0,8'h5A,0,0);
    tab[5]  = mk(0,0, 0, 8'h00,0,  0,0,0,8'h5A,1,0);
    tab[6]  = mk(1,0, 9, 8'h00,0,  0,0,0,8'h5A,0,0);
    tab[7]  = mk(0,1,12, 8'h77,0,  1,0,1,8'hC3,0,0);
    tab[8]  = mk(1,0,12, 8'h00,0,  0,1,0,8'hC3,0,0);
    tab[9]  = mk(0,1,12, 8'h88,0,  1,0,1,8'h77,1,0);
    tab[10] = mk(1,0,11, 8'h00,0,  0,1,0,8'h77,0,0);
    tab[11] = mk(1,1, 1, 8'hFF,0,  0,0,1,8'h00,1,0);
    tab[12] = mk(1,0, 1, 8'h00,0,  0,0,0,8'h00,0,1);
    tab[13] = mk(0,0, 0, 8'h00,1,  0,0,1,8'h00,0,1);
    tab[14] = mk(0,0, 0, 8'h00,0,  0,0,0,8'h00,0,0);
    tab[15] = mk(0,1,10, 8'h42,0,  1,0,0,8'h00,0,0);
    tab[16] = mk(0,1, 3, 8'h99,0,  0,1,0,8'h00,0,0);
    tab[17] = mk(1,0,10, 8'h00,0,  0,0,0,8'h00,1,1);
    tab[18] = mk(1,0, 3, 8'h00,1,  0,0,1,8'h42,0,1);
    tab[19] = mk(0,0, 0, 8'h00,0,  0,0,1,8'h00,0,0);
    tab[20] = mk(1,1, 5, 8'h00,1,  0,0,0,8'h00,0,0);
    tab[21] = mk(0,0, 0, 8'h00,0,  0,0,0,8'h00,0,1);
    tab[22] = mk(0,0, 0, 8'h00,1,  0,0,0,8'h00,0,1);
    tab[23] = mk(1,0,12, 8'h00,0,  0,0,0,8'h00,0,0);

    cyc = 0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    chk1("reset Busy", Busy, 1'b0);
    chk1("reset RdValid", RdValid, 1'b0);
    chk8("reset RdData", RdData, 8'h00);
    @(negedge Clock); ResetN = 1'b1;
    @(posedge Clock); #1;

    for (int i = 0; i < 24; i++) begin
      apply(tab[i].r, tab[i].w, tab[i].a, tab[i].d, tab[i].c,
            $sformatf("row%0d", i), 1'b1, tab[i], s);
    end
    idle("tab tail");  // RdValid for mem[12] = 0x88

    // Reset in the middle of a commit discards the pending write.
    apply(1'b1, 1'b0, 4'd9, '0, 1'b0, "pre-rst rd", 1'b0, none_v, s);
    apply(1'b0, 1'b1, 4'd13, 8'hEE, 1'b0, "pre-rst wr", 1'b0, none_v, s);
    chk1("mid-commit Busy before reset", Busy, 1'b1);
    Read = 1'b0; Write = 1'b0; ErrClear = 1'b0;
    ResetN = 1'b0;
    #1;
    chk1("async rst Busy", Busy, 1'b0);
    chk8("async rst RdData", RdData, 8'h00);
    chk1("async rst RdValid", RdValid, 1'b0);
    chk1("async rst WrDone", WrDone, 1'b0);
    chk1("async rst ProtoErr", ProtoErr, 1'b0);
    chk1("async rst SlowRAM", SlowRAM, 1'b0);
    model_reset();
    @(negedge Clock); ResetN = 1'b1;
    @(posedge Clock); #1;
    apply(1'b1, 1'b0, 4'd3, '0, 1'b0, "post-rst rd3", 1'b0, none_v, s);
    apply(1'b1, 1'b0, 4'd13, '0, 1'b0, "post-rst rd13", 1'b0, none_v, s);
    apply(1'b1, 1'b0, 4'd2, '0, 1'b0, "post-rst rd2", 1'b0, none_v, s);
    idle("post-rst tail");

    // Random traffic, including protocol violations and error clears.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom % 3) == 0, ($urandom % 3) == 0, AW'($urandom),
            DW'($urandom), ($urandom % 8) == 0, "rand", 1'b0, none_v, s);
    end

    // Closed loop: initiator inserts one Delay cycle whenever SlowRAM is seen.
    idle("loop pre0");
    apply(1'b0, 1'b0, '0, '0, 1'b1, "loop clr", 1'b0, none_v, s);
    idle("loop pre1");
    n_delay = 0;
    n_slow_wr = 0;
    for (int t = 0; t < 100; t++) begin
      logic [AW-1:0] a;
      logic          wr;
      a  = (t % 2) ? AW'(10) : AW'(4);
      wr = (t % 4) >= 2;
      if (wr && a == AW'(10)) n_slow_wr++;
      apply(~wr, wr, a, DW'(t), 1'b0, "loop", 1'b0, none_v, s);
      if (s) begin
        n_delay++;
        idle("loop delay");
      end
    end
    idle("loop tail");
    chk8("loop delay count", 8'(n_delay), 8'(n_slow_wr));
    chk1("loop ProtoErr", ProtoErr, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/slow_ram_responder.md
Name: slow_ram_responder

Overview:
Memory-side responder for the Read/Write strobe protocol driven by the team's read/write sequencing FSM. It holds a small register-array RAM and services single-cycle Read and Write strobes. It returns SlowRAM during a write cycle that targets the slow region, so the initiator inserts its Delay state while the responder completes the commit. It also flags protocol violations from the initiator.

Parameters:
AW, 4, address width; RAM depth is 2**AW words
DW, 8, data width
SLOW_BASE, 8, first address of the slow region; addresses >= SLOW_BASE are slow
DELAY, 1, busy cycles for a slow write; must be 1 for compatibility with the existing initiator

Ports:
Clock  in  1  rising-edge clock
ResetN  in  1  asynchronous active-low reset
Read  in  1  read strobe, one cycle
Write  in  1  write strobe, one cycle
Addr  in  AW  access address, valid with the strobe
WrData  in  DW  write data, valid with Write
ErrClear  in  1  synchronous clear of ProtoErr
SlowRAM  out  1  combinational; high in the Write cycle of an accepted slow write
RdData  out  DW  registered read data
RdValid  out  1  one-cycle pulse qualifying RdData
WrDone  out  1  one-cycle pulse when a write is committed
Busy  out  1  high while a slow write is pending
ProtoErr  out  1  sticky protocol-error flag

Behaviour:
- Reset: one clock, asynchronous, active-low. ResetN low immediately clears the state to IDLE, every RAM word to 0, the pending registers, RdData, RdValid, WrDone, Busy, ProtoErr and the busy counter. Reset asserted mid-commit discards the pending write.
- States: IDLE and COMMIT. Busy = (state == COMMIT).
- Fast write (IDLE, Write=1, Read=0, Addr < SLOW_BASE):
  - SlowRAM=0.
  - mem[Addr] is written at the edge ending cycle N.
  - WrDone=1 in cycle N+1.
- Slow write (IDLE, Write=1, Read=0, Addr >= SLOW_BASE):
  - SlowRAM=1 combinationally in cycle N.
  - Addr and WrData are latched into the pending registers; state goes to COMMIT and the counter loads DELAY.
  - Each COMMIT cycle decrements the counter. On the last COMMIT cycle, mem[pending addr] is written and the state returns to IDLE.
  - WrDone=1 in the cycle after the last COMMIT cycle. With DELAY=1: Write in N, COMMIT in N+1, WrDone in N+2.
- Read (Read=1, Write=0, any state):
  - RdData <= mem[Addr] and RdValid=1 in cycle N+1.
  - If Busy and Addr equals the pending address, RdData takes the pending WrData (bypass).
  - A fast write in cycle N-1 is already visible to a read in cycle N.
- SlowRAM is 0 in every cycle except an accepted slow write; it is never asserted in COMMIT.
- Protocol errors set ProtoErr at the next edge and cause the access to be dropped: no RAM update, no RdValid, no WrDone, SlowRAM=0.
  - Read and Write both high in the same cycle.
  - Write while Busy. The pending commit still completes normally.
- ErrClear=1 clears ProtoErr at the next edge. A simultaneous new error wins: the flag stays 1.
- Address wrap is not applicable: Addr spans exactly the full depth.
- RdValid and WrDone are never high for two consecutive cycles from a single strobe.

Decomposition:
- Shared package: state encoding (ST_Idle, ST_Commit) and the default AW/DW/SLOW_BASE constants, shared with the initiator FSM and the bench.
- One natural sub-module, ram_array: a 2**AW x DW register array with synchronous write and combinational read, plus reset-to-zero. The responder FSM, bypass and error logic stay in the top module.

Test Plan:
1. Reset: ResetN=0 mid-simulation -> all outputs 0 immediately; after release, Read Addr=3 gives RdData=0x00 and RdValid=1 one cycle later.
2. Fast write/read: Write Addr=2 WrData=0x5A -> SlowRAM=0, WrDone next cycle; Read Addr=2 on the following cycle -> RdData=0x5A with RdValid.
3. Slow write: Write Addr=9 WrData=0xC3 -> SlowRAM=1 in the same cycle, Busy=1 for 1 cycle, WrDone 2 cycles after the strobe; a later Read Addr=9 -> 0xC3.
4. Bypass: slow Write Addr=12 WrData=0x77, then Read Addr=12 during COMMIT -> RdData=0x77 next cycle; Read Addr=11 during COMMIT -> old contents.
5. Protocol errors:
   - Read=Write=1 at Addr=1 -> ProtoErr=1, mem[1] unchanged, no RdValid or WrDone.
   - Write during Busy -> dropped; the pending write still commits.
   - ErrClear -> ProtoErr=0.
6. Closed loop with the existing initiator FSM, SlowRAM tied back: alternating Addr 4/10 -> Read, Write, Delay sequence on slow addresses only; no ProtoErr over 100 transactions.
